pipe_hazard_ctrl: RTL and testbench

Central pipeline stall/flush sequencer for the 5-stage pipelined CPU. It takes the load-use detect, the taken-branch resolve and the data-memory request/ready handshake, and arbitrates them into one consistent set of PC, IF/ID and stage-register hold/flush controls. It also times out a hung data-memory access into a sticky error state. It sits beside the pipeline registers in the CPU top and drives their enables and flush inputs.

---
 rtl/pipe_hazard_ctrl_if.sv | 32 +++
 rtl/pipe_hazard_ctrl.sv | 109 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus: hazard/handshake inputs from the pipeline and the
// resulting PC / pipeline-register controls plus status and perf counters.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             load_use_i;
  logic             branch_taken_i;
  logic             mem_req_i;
  logic             mem_ready_i;
  logic             pc_write_o;
  logic             ifid_write_o;
  logic             ifid_flush_o;
  logic             idex_flush_o;
  logic             exmem_flush_o;
  logic             pipe_hold_o;
  logic             err_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  // master: the CPU pipeline side; slave: the hazard controller
  modport master (
    output load_use_i, branch_taken_i, mem_req_i, mem_ready_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o,
           exmem_flush_o, pipe_hold_o, err_o, state_o, stall_cnt_o, flush_cnt_o
  );
  modport slave (
    input  load_use_i, branch_taken_i, mem_req_i, mem_ready_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o,
           exmem_flush_o, pipe_hold_o, err_o, state_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush sequencer: memory freeze > branch flush > load-use stall,
// with a data-memory timeout into a sticky ERR. HAZ_PERF_CNT_EN adds perf counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  pipe_hazard_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {RUN = 2'b00, MEM_WAIT = 2'b01, ERR = 2'b10} state_t;

  localparam logic [7:0] LP_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     r_state;
  logic [7:0] r_wait_cnt;

  logic w_freeze, w_pc_write, w_ifid_write, w_ifid_flush, w_idex_flush;
  logic w_exmem_flush, w_hold, w_err;

  // On the MEM_WAIT release cycle the freeze term drops and branch/load-use
  // resolve exactly as they would in RUN.
  always_comb begin
    w_freeze      = 1'b1;
    w_err         = 1'b0;
    w_pc_write    = 1'b1;
    w_ifid_write  = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_flush  = 1'b0;
    w_exmem_flush = 1'b0;
    w_hold        = 1'b0;
    case (r_state)
      RUN:      w_freeze = bus.mem_req_i & ~bus.mem_ready_i;
      MEM_WAIT: w_freeze = ~bus.mem_ready_i;
      ERR: begin
        w_freeze = 1'b1;
        w_err    = 1'b1;
      end
      default:  w_freeze = 1'b1;
    endcase
    if (w_freeze) begin
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_hold       = 1'b1;
    end else if (bus.branch_taken_i) begin
      w_ifid_flush  = 1'b1;
      w_idex_flush  = 1'b1;
      w_exmem_flush = 1'b1;
    end else if (bus.load_use_i) begin
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= RUN;
      r_wait_cnt <= 8'd0;
    end else begin
      case (r_state)
        RUN: if (w_freeze) begin
          r_state    <= MEM_WAIT;
          r_wait_cnt <= 8'd0;
        end
        MEM_WAIT: begin
          if (bus.mem_ready_i)                  r_state <= RUN;
          else if (r_wait_cnt == LP_WAIT_LAST)  r_state <= ERR;
          else                                  r_wait_cnt <= r_wait_cnt + 8'd1;
        end
        ERR:     r_state <= ERR;
        default: r_state <= RUN;
      endcase
    end
  end

  assign bus.pc_write_o    = w_pc_write;
  assign bus.ifid_write_o  = w_ifid_write;
  assign bus.ifid_flush_o  = w_ifid_flush;
  assign bus.idex_flush_o  = w_idex_flush;
  assign bus.exmem_flush_o = w_exmem_flush;
  assign bus.pipe_hold_o   = w_hold;
  assign bus.err_o         = w_err;
  assign bus.state_o       = r_state;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  // Saturating counters; ERR cycles are not counted as stalls.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (r_state != ERR && !w_pc_write && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_ifid_flush && r_flush_cnt != '1)
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign bus.stall_cnt_o = r_stall_cnt;
  assign bus.flush_cnt_o = r_flush_cnt;
`else
  localparam logic [CNT_W-1:0] LP_CNT_ZERO = '0;
  assign bus.stall_cnt_o = LP_CNT_ZERO;
  assign bus.flush_cnt_o = LP_CNT_ZERO;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, timeout/async-reset
// sequences and random stimulus against a rule-level reference model.
module tb_pipe_hazard_ctrl;
  localparam int TMO = 4;
  localparam int CW  = 16;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) bus();
  pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode 0=run, 1=waiting on memory, 2=error
  int          m_mode;
  int          m_waited;
  int unsigned m_stall, m_flush;

  // packed outputs: {pc_write, ifid_write, ifid_flush, idex_flush, exmem_flush, hold, err, state[1:0]}
  localparam logic [8:0] D   = 9'b11_000_0_0_00;
  localparam logic [8:0] F0  = 9'b00_000_1_0_00;
  localparam logic [8:0] F1  = 9'b00_000_1_0_01;
  localparam logic [8:0] FE  = 9'b00_000_1_1_10;
  localparam logic [8:0] LU0 = 9'b00_010_0_0_00;
  localparam logic [8:0] LU1 = 9'b00_010_0_0_01;
  localparam logic [8:0] BR0 = 9'b11_111_0_0_00;
  localparam logic [8:0] BR1 = 9'b11_111_0_0_01;

  logic [8:0] act;
  assign act = {bus.pc_write_o, bus.ifid_write_o, bus.ifid_flush_o, bus.idex_flush_o,
                bus.exmem_flush_o, bus.pipe_hold_o, bus.err_o, bus.state_o};

  typedef struct packed {
    logic lu, br, rq, rd;
    logic [8:0] exp;
  } vec_t;
  vec_t tbl[13];

  function automatic vec_t mk(logic lu, logic br, logic rq, logic rd, logic [8:0] e);
    vec_t v;
    v.lu = lu; v.br = br; v.rq = rq; v.rd = rd; v.exp = e;
    return v;
  endfunction

  function automatic logic [8:0] model_out(int mode, logic lu, logic br, logic rq, logic rd);
    logic [1:0] st;
    logic       frz;
    st  = (mode == 0) ? 2'b00 : (mode == 1) ? 2'b01 : 2'b10;
    frz = (mode == 2) || (mode == 1 && !rd) || (mode == 0 && rq && !rd);
    if (frz)        return {2'b00, 3'b000, 1'b1, (mode == 2), st};
    else if (br)    return {2'b11, 3'b111, 2'b00, st};
    else if (lu)    return {2'b00, 3'b010, 2'b00, st};
    else            return {2'b11, 3'b000, 2'b00, st};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int unsigned exp_cnt(int unsigned v);
`ifdef HAZ_PERF_CNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic model_reset();
    m_mode = 0; m_waited = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic model_step(input logic lu, input logic br, input logic rq, input logic rd);
    logic [8:0] o;
    o = model_out(m_mode, lu, br, rq, rd);
    if (m_mode != 2 && !o[8] && m_stall < (2**CW - 1)) m_stall++;
    if (o[6] && m_flush < (2**CW - 1)) m_flush++;
    if (m_mode == 0 && rq && !rd) begin
      m_mode = 1; m_waited = 0;
    end else if (m_mode == 1) begin
      if (rd) m_mode = 0;
      else begin
        m_waited++;
        if (m_waited == TMO) m_mode = 2;
      end
    end
  endtask

  task automatic drive(input logic lu, input logic br, input logic rq, input logic rd);
    bus.load_use_i = lu; bus.branch_taken_i = br; bus.mem_req_i = rq; bus.mem_ready_i = rd;
  endtask

  task automatic cycle(input logic lu, input logic br, input logic rq, input logic rd,
                       output logic [8:0] got);
    @(negedge clk_i);
    drive(lu, br, rq, rd);
    #1;
    got = act;
    check("outputs vs model", act, model_out(m_mode, lu, br, rq, rd));
    check("stall_cnt vs model", bus.stall_cnt_o, exp_cnt(m_stall));
    check("flush_cnt vs model", bus.flush_cnt_o, exp_cnt(m_flush));
    model_step(lu, br, rq, rd);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    drive(0, 0, 0, 0);
    model_reset();
    #1;
    check("reset outputs", act, D);
    check("reset stall_cnt", bus.stall_cnt_o, 0);
    check("reset flush_cnt", bus.flush_cnt_o, 0);
    #2 rst_i = 1'b1;
  endtask

  initial begin
    logic [8:0] got;
    rst_i = 1'b0;
    drive(0, 0, 0, 0);
    model_reset();

    tbl[0]  = mk(0, 0, 0, 0, D);
    tbl[1]  = mk(1, 0, 0, 0, LU0);
    tbl[2]  = mk(0, 0, 0, 0, D);
    tbl[3]  = mk(1, 1, 0, 0, BR0);
    tbl[4]  = mk(0, 0, 1, 1, D);
    tbl[5]  = mk(0, 1, 1, 0, F0);
    tbl[6]  = mk(0, 1, 1, 0, F1);
    tbl[7]  = mk(0, 1, 1, 0, F1);
    tbl[8]  = mk(0, 1, 1, 1, BR1);
    tbl[9]  = mk(0, 0, 0, 0, D);
    tbl[10] = mk(1, 0, 1, 0, F0);
    tbl[11] = mk(1, 0, 1, 1, LU1);
    tbl[12] = mk(0, 0, 0, 0, D);

    do_reset();
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].lu, tbl[i].br, tbl[i].rq, tbl[i].rd, got);
      check($sformatf("table[%0d]", i), got, tbl[i].exp);
    end
    @(posedge clk_i); #1;
    check("table stall total", bus.stall_cnt_o, exp_cnt(6));
    check("table flush total", bus.flush_cnt_o, exp_cnt(2));

    // Timeout: RUN entry cycle plus TMO unready wait cycles, then sticky ERR
    do_reset();
    for (int i = 0; i <= TMO; i++) begin
      cycle(0, 0, 1, 0, got);
      check("timeout freeze", got, (i == 0) ? F0 : F1);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 1, 1, got);
      check("err sticky", got, FE);
    end
    check("err stall total", bus.stall_cnt_o, exp_cnt(TMO + 1));

    // Asynchronous reset in the middle of a memory wait
    do_reset();
    cycle(1, 0, 0, 0, got);
    cycle(0, 0, 1, 0, got);
    cycle(0, 0, 1, 0, got);
    @(posedge clk_i); #2;
    rst_i = 1'b0;
    #1;
    check("async reset state", bus.state_o, 2'b00);
    check("async reset outputs", act, F0);
    check("async reset stall_cnt", bus.stall_cnt_o, 0);
    check("async reset flush_cnt", bus.flush_cnt_o, 0);
    model_reset();
    @(negedge clk_i); #1 rst_i = 1'b1;
    drive(0, 0, 0, 0);
    cycle(0, 0, 0, 0, got);
    check("after async reset idle", got, D);

    // Random phase; readiness probability varies so ERR is also reached
    do_reset();
    for (int seg = 0; seg < 3; seg++) begin
      for (int n = 0; n < 1500; n++) begin
        logic lu, br, rq, rd;
        lu = ($urandom % 4) == 0;
        br = ($urandom % 4) == 0;
        rq = ($urandom % 2) == 0;
        rd = ($urandom % (seg + 2)) == 0;
        cycle(lu, br, rq, rd, got);
        if (m_mode == 2 && ($urandom % 6) == 0) do_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
